// File: rtl/enc_trig_sched.sv
// Distance-based acquisition trigger scheduler fed by the encoder position path.
// Optional build: define ENC_TRIG_FWD_ONLY_EN to trigger on forward travel only.
module enc_trig_sched #(
    parameter int PULSE_W = 8,
    parameter int MISS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic [15:0]       i_step,
    input  logic [31:0]       i_pos,
    input  logic              i_pos_valid,
    input  logic              i_acq_busy,
    output logic              o_trig,
    output logic [31:0]       o_trig_cnt,
    output logic [MISS_W-1:0] o_missed,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_FIRE = 2'd3
    } state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_W);

    state_t      state;
    logic [31:0] pos_q;
    logic [31:0] anchor;
    logic [15:0] step_q;
    logic [7:0]  pulse_cnt;

    logic [31:0] delta;
    logic [31:0] mag;
    logic [31:0] step_ext;
    logic        crossing;
    logic        fwd;
    logic        counts;

    // Negating 0x80000000 yields 0x80000000, which read as unsigned is exactly 2^31.
    always_comb begin
        delta    = pos_q - anchor;
        mag      = delta[31] ? (~delta + 32'd1) : delta;
        step_ext = {16'd0, step_q};
        crossing = (mag >= step_ext);
        fwd      = ~delta[31];
`ifdef ENC_TRIG_FWD_ONLY_EN
        counts   = fwd;
`else
        counts   = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pos_q      <= 32'd0;
            anchor     <= 32'd0;
            step_q     <= 16'd0;
            pulse_cnt  <= 8'd0;
            o_trig     <= 1'b0;
            o_trig_cnt <= 32'd0;
            o_missed   <= '0;
        end else begin
            if (i_pos_valid)
                pos_q <= i_pos;

            if (state != S_IDLE && !i_enable) begin
                state  <= S_IDLE;
                o_trig <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        o_trig <= 1'b0;
                        if (i_enable && i_step != 16'd0)
                            state <= S_ARM;
                    end
                    S_ARM: begin
                        step_q     <= i_step;
                        anchor     <= pos_q;
                        o_trig_cnt <= 32'd0;
                        o_missed   <= '0;
                        // A zero step here would cross every cycle, so fall back to IDLE.
                        state      <= (i_step == 16'd0) ? S_IDLE : S_WAIT;
                    end
                    S_WAIT: begin
                        if (crossing) begin
                            anchor <= fwd ? (anchor + step_ext) : (anchor - step_ext);
                            if (counts) begin
                                if (i_acq_busy) begin
                                    if (o_missed != {MISS_W{1'b1}})
                                        o_missed <= o_missed + 1'b1;
                                end else begin
                                    state      <= S_FIRE;
                                    o_trig     <= 1'b1;
                                    o_trig_cnt <= o_trig_cnt + 32'd1;
                                    pulse_cnt  <= 8'd1;
                                end
                            end
                        end
                    end
                    S_FIRE: begin
                        if (pulse_cnt >= PULSE_LAST) begin
                            state  <= S_WAIT;
                            o_trig <= 1'b0;
                        end else begin
                            pulse_cnt <= pulse_cnt + 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_enc_trig_sched.sv
// Randomized scoreboard bench for enc_trig_sched; honours ENC_TRIG_FWD_ONLY_EN.
module tb_enc_trig_sched;

    localparam int PULSE_W = 8;
    localparam int MISS_W  = 16;
`ifdef ENC_TRIG_FWD_ONLY_EN
    localparam bit FWD_ONLY = 1'b1;
`else
    localparam bit FWD_ONLY = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              i_enable;
    logic [15:0]       i_step;
    logic [31:0]       i_pos;
    logic              i_pos_valid;
    logic              i_acq_busy;
    logic              o_trig;
    logic [31:0]       o_trig_cnt;
    logic [MISS_W-1:0] o_missed;
    logic [1:0]        o_state;

    enc_trig_sched #(.PULSE_W(PULSE_W), .MISS_W(MISS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_step     (i_step),
        .i_pos      (i_pos),
        .i_pos_valid(i_pos_valid),
        .i_acq_busy (i_acq_busy),
        .o_trig     (o_trig),
        .o_trig_cnt (o_trig_cnt),
        .o_missed   (o_missed),
        .o_state    (o_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int exp_q[$];
    logic [31:0] m_anchor;
    int          m_step;
    int          m_cnt;
    int          m_missed;

    int strobe_cyc;
    int last_rise = -1;
    int prev_rise = -1;
    bit abort_pulse = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Distance model: walk the anchor one step at a time toward the new position.
    task automatic modelPos(input logic [31:0] pos, output int n);
        int     d;
        longint m;
        bit     fwd;
        n = 0;
        d = int'(pos - m_anchor);
        m = (d < 0) ? -longint'(d) : longint'(d);
        while (m >= longint'(m_step)) begin
            n++;
            fwd = (d > 0);
            m_anchor = fwd ? m_anchor + 32'(m_step) : m_anchor - 32'(m_step);
            if (fwd || !FWD_ONLY) begin
                if (i_acq_busy) begin
                    if (m_missed < (1 << MISS_W) - 1) m_missed++;
                end else begin
                    m_cnt++;
                    exp_q.push_back(m_cnt);
                end
            end
            d = int'(pos - m_anchor);
            m = (d < 0) ? -longint'(d) : longint'(d);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pos, output int n);
        i_pos       = pos;
        i_pos_valid = 1'b1;
        strobe_cyc  = cyc;
        tick();
        i_pos_valid = 1'b0;
        modelPos(pos, n);
    endtask

    task automatic settle(input int n);
        repeat (n * (PULSE_W + 2) + 4) tick();
    endtask

    task automatic moveTo(input logic [31:0] pos);
        int n;
        applyStimulus(pos, n);
        settle(n);
    endtask

    task automatic startScenario(input int step, input logic [31:0] pos0);
        i_enable = 1'b0;
        tick();
        tick();
        i_pos       = pos0;
        i_pos_valid = 1'b1;
        tick();
        i_pos_valid = 1'b0;
        i_step   = 16'(step);
        i_enable = 1'b1;
        repeat (3) tick();
        m_anchor = pos0;
        m_step   = step;
        m_cnt    = 0;
        m_missed = 0;
        checkOutput("armed_state", o_state, 2);
        checkOutput("armed_trig_cnt", o_trig_cnt, 0);
        checkOutput("armed_missed", o_missed, 0);
    endtask

    task automatic endCheck(input string name);
        checkOutput({name, "_trig_cnt"}, o_trig_cnt, m_cnt);
        checkOutput({name, "_missed"}, o_missed, m_missed);
        checkOutput({name, "_pending"}, exp_q.size(), 0);
        checkOutput({name, "_state"}, o_state, 2);
    endtask

    task automatic waitRise();
        for (int i = 0; i < 20 && !o_trig; i++) tick();
        checkOutput("rise_timeout", o_trig, 1);
    endtask

    // Monitor: every rising trigger consumes one scoreboard entry, every fall checks width.
    initial begin
        bit prev_trig = 1'b0;
        int width = 0;
        int exp_cnt;
        forever begin
            @(posedge clk);
            #1;
            if (o_trig && !prev_trig) begin
                prev_rise = last_rise;
                last_rise = cyc;
                width = 1;
                checkOutput("trig_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_cnt = exp_q.pop_front();
                    checkOutput("trig_cnt_at_rise", o_trig_cnt, exp_cnt);
                end
            end else if (o_trig) begin
                width++;
            end else if (prev_trig) begin
                if (!abort_pulse) checkOutput("pulse_width", width, PULSE_W);
                abort_pulse = 1'b0;
            end
            prev_trig = o_trig;
        end
    end

    initial begin
        int n;
        int step;
        int pos;
        rst         = 1'b1;
        i_enable    = 1'b0;
        i_step      = 16'd0;
        i_pos       = 32'd0;
        i_pos_valid = 1'b0;
        i_acq_busy  = 1'b0;
        repeat (3) tick();
        checkOutput("reset_state", o_state, 0);
        checkOutput("reset_trig", o_trig, 0);
        checkOutput("reset_trig_cnt", o_trig_cnt, 0);
        checkOutput("reset_missed", o_missed, 0);
        rst = 1'b0;
        tick();

        // Basic forward travel with latency check on the first crossing
        startScenario(100, 32'd0);
        moveTo(32'd50);
        applyStimulus(32'd100, n);
        settle(n);
        checkOutput("trig_latency", last_rise - strobe_cyc, 2);
        moveTo(32'd199);
        moveTo(32'd200);
        endCheck("basic");

        // Busy drop, then release
        startScenario(10, 32'd0);
        i_acq_busy = 1'b1;
        moveTo(32'd35);
        endCheck("busy");
        i_acq_busy = 1'b0;
        moveTo(32'd40);
        endCheck("busy_release");

        // Backlog drains as back-to-back pulses
        startScenario(10, 32'd0);
        moveTo(32'd30);
        checkOutput("backlog_gap", last_rise - prev_rise, PULSE_W + 1);
        endCheck("backlog");

        // Signed wrap and reverse travel
        startScenario(4, 32'h7FFF_FFFE);
        moveTo(32'h8000_0002);
        endCheck("wrap");
        startScenario(4, 32'd0);
        moveTo(32'hFFFF_FFF8);
        endCheck("reverse");

        // Enable drop three cycles into a pulse
        startScenario(10, 32'd0);
        abort_pulse = 1'b1;
        applyStimulus(32'd10, n);
        waitRise();
        tick();
        tick();
        i_enable = 1'b0;
        tick();
        checkOutput("abort_trig", o_trig, 0);
        checkOutput("abort_state", o_state, 0);
        checkOutput("abort_trig_cnt", o_trig_cnt, 1);

        // Reset in the middle of a pulse
        startScenario(10, 32'd0);
        abort_pulse = 1'b1;
        applyStimulus(32'd10, n);
        waitRise();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_abort_trig", o_trig, 0);
        checkOutput("rst_abort_state", o_state, 0);
        checkOutput("rst_abort_trig_cnt", o_trig_cnt, 0);
        checkOutput("rst_abort_missed", o_missed, 0);
        rst = 1'b0;
        tick();

        // Zero step never arms
        i_step   = 16'd0;
        i_enable = 1'b1;
        i_pos       = 32'd1000;
        i_pos_valid = 1'b1;
        tick();
        i_pos_valid = 1'b0;
        repeat (20) tick();
        checkOutput("step0_state", o_state, 0);
        checkOutput("step0_trig", o_trig, 0);

        // Randomized travel
        for (int s = 0; s < 20; s++) begin
            step = $urandom_range(1, 40);
            pos  = ($urandom_range(0, 2) == 0) ? int'(32'h7FFF_FFF0 + $urandom_range(0, 31)) : int'($urandom);
            startScenario(step, 32'(pos));
            for (int u = 0; u < 8; u++) begin
                i_acq_busy = ($urandom_range(0, 3) == 0);
                pos = pos + int'($urandom_range(0, 4 * step)) - 2 * step;
                moveTo(32'(pos));
            end
            i_acq_busy = 1'b0;
            endCheck("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
